// File: rtl/mul_seq_32_pkg.sv
// Purpose : shared constants and FSM encoding for the sequential multiplier.
// Contents: ITERS (shift-and-add iterations), ADD_W (shared adder width),
//           state_t (controller state encoding).
package mul_seq_32_pkg;

  localparam int unsigned ITERS = 32;
  localparam int unsigned ADD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : mul_seq_32_pkg

// File: rtl/add_32.sv
// Purpose : 32-bit ripple-carry adder shared between the ALU and the
//           multiply unit.
// Ports   : i_a, i_b    - addends
//           i_carry     - carry in
//           o_sum       - 32-bit sum
//           o_carry     - carry out of bit 31
//           o_overflow  - signed overflow (carry into msb != carry out)
module add_32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_carry,
  output logic [31:0] o_sum,
  output logic        o_carry,
  output logic        o_overflow
);

  logic [32:0] w_c;

  assign w_c[0] = i_carry;

  // One full-adder cell per bit, carry rippling upward.
  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_carry    = w_c[32];
  assign o_overflow = w_c[32] ^ w_c[31];

endmodule : add_32

// File: rtl/mul_seq_32.sv
// Purpose : multi-cycle unsigned 32x32->64 multiplier. Reuses one add_32 as
//           a shift-and-add datapath, one iteration per clock, fixed 32
//           iterations, start/busy/done handshake toward the ALU issue logic.
// Ports   : clk     - clock, rising edge
//           rst     - asynchronous active-high reset
//           start   - request, sampled only while idle
//           a, b    - multiplicand / multiplier, captured on accepted start
//           busy    - high while running and in the done cycle
//           done    - one-cycle pulse, product valid
//           product - 64-bit result, held until the next accepted start
module mul_seq_32
  import mul_seq_32_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // Elaboration-time parameter guards.
  if (WIDTH != ADD_W) begin : g_bad_width
    $error("mul_seq_32: WIDTH must be 32 to match add_32");
  end
  if ((2 ** CNT_W) <= WIDTH) begin : g_bad_cnt
    $error("mul_seq_32: CNT_W too narrow for WIDTH iterations");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_product;

  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_carry;
  logic                 w_unused_ovf;

  // Add the multiplicand only when the current multiplier bit is set.
  assign w_addend = r_lo[0] ? r_mcand : '0;

  add_32 u_add (
    .i_a        (r_hi),
    .i_b        (w_addend),
    .i_carry    (1'b0),
    .o_sum      (w_sum),
    .o_carry    (w_carry),
    .o_overflow (w_unused_ovf)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start)             w_state_nxt = ST_RUN;
      ST_RUN:  if (r_cnt == CNT_LAST) w_state_nxt = ST_DONE;
      ST_DONE:                        w_state_nxt = ST_IDLE;
      default:                        w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode; in the done cycle the live accumulator is presented so the
  // product is valid together with the done pulse.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    product = r_product;
    case (r_state)
      ST_RUN: begin
        busy = 1'b1;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        product = {r_hi, r_lo};
      end
      default: ;
    endcase
  end

  // Datapath: operand capture, shift-and-add step, result hold.
  // The adder carry becomes the new hi msb so partial sums above 2^32-1
  // are not lost; the sum lsb shifts into lo as the multiplier shifts out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mcand <= a;
            r_lo    <= b;
            r_hi    <= '0;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          r_hi  <= {w_carry, w_sum[WIDTH-1:1]};
          r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        ST_DONE: begin
          r_product <= {r_hi, r_lo};
        end
        default: ;
      endcase
    end
  end

endmodule : mul_seq_32

// File: tb/tb_mul_seq_32.sv
// Self-checking bench for mul_seq_32: directed scenarios plus randomized
// operands compared against a plain 64-bit multiply.
module tb_mul_seq_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_seq_32 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xx;
    logic [63:0] yy;
    xx = {32'd0, x};
    yy = {32'd0, y};
    return xx * yy;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from idle and wait for done. lat counts cycles from
  // the accepting edge's cycle (inclusive) to the done cycle.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input bit scramble,
                        output logic [63:0] res, output int lat, output bit ok);
    int guard;
    guard = 0;
    while (busy && guard < 100) begin
      tick();
      guard++;
    end
    a = ia;
    b = ib;
    start = 1'b1;
    tick();
    lat = 1;
    start = 1'b0;
    if (scramble) begin
      a = $urandom;
      b = $urandom;
    end
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    ok  = done;
    res = product;
  endtask

  task automatic test_reset();
    logic [63:0] res;
    int lat;
    bit ok;
    int n_done;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) tick();
    n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (product !== '0)  begin n_fail++; $display("FAIL reset_product got=%h exp=0", product); end
    rst = 1'b0;
    tick();
    a = 32'd123; b = 32'd456; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrun_busy got=%b exp=1", busy); end
    #3 rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL async_rst_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL async_rst_done got=%b exp=0", done); end
    n_checks++; if (product !== '0) begin n_fail++; $display("FAIL async_rst_product got=%h exp=0", product); end
    repeat (2) tick();
    rst = 1'b0;
    n_done = 0;
    repeat (40) begin
      tick();
      if (done) n_done++;
    end
    n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL rst_no_done got=%0d exp=0", n_done); end
    run_op(32'd3, 32'd5, 1'b0, res, lat, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL post_rst_timeout got=no_done exp=done"); end
    n_checks++; if (res !== 64'd15) begin n_fail++; $display("FAIL post_rst_product got=%h exp=%h", res, 64'd15); end
  endtask

  task automatic test_basic();
    logic [63:0] res;
    int lat;
    bit ok;
    run_op(32'd7, 32'd6, 1'b0, res, lat, ok);
    n_checks++; if (!ok)            begin n_fail++; $display("FAIL basic_timeout got=no_done exp=done"); end
    n_checks++; if (lat != 33)      begin n_fail++; $display("FAIL basic_latency got=%0d exp=33", lat); end
    n_checks++; if (res !== 64'd42) begin n_fail++; $display("FAIL basic_product got=%h exp=%h", res, 64'd42); end
    tick();
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    n_checks++; if (product !== 64'd42) begin n_fail++; $display("FAIL basic_hold got=%h exp=%h", product, 64'd42); end
  endtask

  task automatic test_carry();
    logic [63:0] res;
    int lat;
    bit ok;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, res, lat, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL carry_timeout got=no_done exp=done"); end
    n_checks++; if (res !== 64'hFFFF_FFFE_0000_0001)
      begin n_fail++; $display("FAIL carry_product got=%h exp=%h", res, 64'hFFFF_FFFE_0000_0001); end
  endtask

  task automatic test_zeros_identity();
    logic [63:0] res;
    int lat;
    bit ok;
    run_op(32'd0, 32'h1234_5678, 1'b0, res, lat, ok);
    n_checks++; if (!ok || lat != 33) begin n_fail++; $display("FAIL zero_latency got=%0d exp=33", lat); end
    n_checks++; if (res !== 64'd0)    begin n_fail++; $display("FAIL zero_product got=%h exp=0", res); end
    run_op(32'd1, 32'h8000_0000, 1'b0, res, lat, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ident_timeout got=no_done exp=done"); end
    n_checks++; if (res !== 64'h0000_0000_8000_0000)
      begin n_fail++; $display("FAIL ident_product got=%h exp=%h", res, 64'h0000_0000_8000_0000); end
  endtask

  task automatic test_ignored_start();
    int lat;
    int n_done;
    int guard;
    guard = 0;
    while (busy && guard < 100) begin
      tick();
      guard++;
    end
    a = 32'd10; b = 32'd10; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    repeat (5) begin tick(); lat++; end
    a = 32'd9; b = 32'd9; start = 1'b1;
    tick();
    lat++;
    start = 1'b0;
    while (!done && lat < 100) begin tick(); lat++; end
    n_checks++; if (lat != 33)        begin n_fail++; $display("FAIL ign_latency got=%0d exp=33", lat); end
    n_checks++; if (product !== 64'd100) begin n_fail++; $display("FAIL ign_product got=%h exp=%h", product, 64'd100); end
    n_done = 0;
    repeat (40) begin
      tick();
      if (done) n_done++;
    end
    n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL ign_second_done got=%0d exp=0", n_done); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap;
    int unstable;
    int guard;
    guard = 0;
    while (busy && guard < 100) begin
      tick();
      guard++;
    end
    a = 32'd2; b = 32'd3; start = 1'b1;
    tick();
    a = 32'd4; b = 32'd5;
    lat = 1;
    while (!done && lat < 100) begin tick(); lat++; end
    n_checks++; if (product !== 64'd6) begin n_fail++; $display("FAIL b2b_first got=%h exp=%h", product, 64'd6); end
    gap = 0;
    unstable = 0;
    do begin
      tick();
      gap++;
      if (!done && product !== 64'd6) unstable++;
    end while (!done && gap < 100);
    start = 1'b0;
    n_checks++; if (gap != 34)          begin n_fail++; $display("FAIL b2b_gap got=%0d exp=34", gap); end
    n_checks++; if (unstable != 0)      begin n_fail++; $display("FAIL b2b_stable got=%0d exp=0", unstable); end
    n_checks++; if (product !== 64'd20) begin n_fail++; $display("FAIL b2b_second got=%h exp=%h", product, 64'd20); end
    tick();
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got=%b exp=0", busy); end
  endtask

  task automatic test_random();
    logic [63:0] res;
    logic [31:0] ia;
    logic [31:0] ib;
    int lat;
    bit ok;
    for (int i = 0; i < 12; i++) begin
      ia = $urandom;
      ib = $urandom;
      if (i == 0) ia = 32'hFFFF_FFFF;
      if (i == 1) ib = 32'hFFFF_FFFF;
      run_op(ia, ib, 1'b1, res, lat, ok);
      n_checks++; if (!ok || lat != 33)
        begin n_fail++; $display("FAIL rand_latency[%0d] got=%0d exp=33", i, lat); end
      n_checks++; if (res !== ref_mul(ia, ib))
        begin n_fail++; $display("FAIL rand_product[%0d] a=%h b=%h got=%h exp=%h", i, ia, ib, res, ref_mul(ia, ib)); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_zeros_identity();
    test_ignored_start();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mul_seq_32
